vga_timing_ctrl: RTL and testbench

Frame sequencer for the 640x480@60 VGA output path. It drives a horizontal pixel counter (0–799) and a vertical line counter (0–524) from a pixel-rate tick, and decodes active-low hsync/vsync, video_on and pixel coordinates for the pixel generator. It owns start/stop sequencing so that the display never sees a truncated frame. It sits between the clock-enable divider and the pixel/colour logic.

---
 rtl/vga_pkg.sv | 27 ++
 rtl/vga_timing_ctrl_mod_counter.sv | 35 +++
 rtl/vga_timing_ctrl.sv | 140 ++++++++++++++
 tb/tb_vga_timing_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared definitions for the VGA timing path.
//   - default 640x480@60 timing constants and their derived totals
//   - counter width used by every counter in the path
//   - sequencer state encoding
package vga_pkg;

    localparam int unsigned CNT_W = 10;

    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FP     = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BP     = 48;
    localparam int unsigned VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FP     = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BP     = 33;
    localparam int unsigned VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_t;

endpackage

// File: rtl/vga_timing_ctrl_mod_counter.sv
// mod_counter: modulo-N up counter with synchronous clear.
//   clk   in  system clock
//   inc   in  advance by one (wraps to 0 when tc is set)
//   clr   in  synchronous clear, dominates inc
//   count out current value
//   tc    out terminal count, count >= N-1
module mod_counter
    import vga_pkg::*;
#(
    parameter int unsigned N = VGA_H_TOTAL
) (
    input  logic             clk,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             tc
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    logic [CNT_W-1:0] r_count;

    // ">=" rather than "==" so an out-of-range value wraps on the next step
    assign tc    = (r_count >= LAST);
    assign count = r_count;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_count <= '0;
        end else if (inc) begin
            r_count <= tc ? '0 : r_count + 1'b1;
        end
    end

endmodule

// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: frame sequencer for the VGA output path.
//   clk         in  system clock
//   rst_n       in  synchronous active-low reset
//   pix_tick    in  pixel-rate enable, one clk wide
//   en          in  run request (level)
//   hCount      out pixel column
//   vCount      out line number
//   hsync       out active-low horizontal sync
//   vsync       out active-low vertical sync
//   video_on    out inside the visible area while running/stopping
//   line_start  out one-clk pulse at the start of every line
//   frame_start out one-clk pulse at the start of every frame
//   busy        out high while running or finishing the last frame
module vga_timing_ctrl
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
    parameter int unsigned H_FP     = VGA_H_FP,
    parameter int unsigned H_SYNC   = VGA_H_SYNC,
    parameter int unsigned H_BP     = VGA_H_BP,
    parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
    parameter int unsigned V_FP     = VGA_V_FP,
    parameter int unsigned V_SYNC   = VGA_V_SYNC,
    parameter int unsigned V_BP     = VGA_V_BP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pix_tick,
    input  logic             en,
    output logic [CNT_W-1:0] hCount,
    output logic [CNT_W-1:0] vCount,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic             line_start,
    output logic             frame_start,
    output logic             busy
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEGIN = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] VS_BEGIN = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    state_t           r_state;
    state_t           w_next;
    logic             r_line_start;
    logic             r_frame_start;
    logic             w_tick;
    logic             w_clr;
    logic             w_h_tc;
    logic             w_v_tc;
    logic             w_line_wrap;
    logic             w_frame_wrap;
    logic             w_enter_run;
    logic [CNT_W-1:0] w_h_count;
    logic [CNT_W-1:0] w_v_count;

    // Ticks only count outside IDLE, so a tick on the IDLE->RUN edge is dropped.
    assign w_tick       = pix_tick && (r_state != ST_IDLE);
    assign w_clr        = !rst_n || (r_state == ST_IDLE);
    assign w_line_wrap  = w_tick && w_h_tc;
    assign w_frame_wrap = w_line_wrap && w_v_tc;
    assign w_enter_run  = (r_state == ST_IDLE) && (w_next == ST_RUN);

    mod_counter #(.N(H_TOTAL)) u_h_cnt (
        .clk   (clk),
        .inc   (w_tick),
        .clr   (w_clr),
        .count (w_h_count),
        .tc    (w_h_tc)
    );

    mod_counter #(.N(V_TOTAL)) u_v_cnt (
        .clk   (clk),
        .inc   (w_line_wrap),
        .clr   (w_clr),
        .count (w_v_count),
        .tc    (w_v_tc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: if (en) w_next = ST_RUN;
            ST_RUN:  if (!en) w_next = ST_STOP;
            ST_STOP: begin
                if (en) begin
                    w_next = ST_RUN;
                end else if (w_frame_wrap) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // The wrap that ends the final frame in STOP returns to IDLE and must not
    // announce a new line or frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_line_start  <= w_enter_run || (w_line_wrap  && (w_next != ST_IDLE));
            r_frame_start <= w_enter_run || (w_frame_wrap && (w_next != ST_IDLE));
        end
    end

    always_comb begin
        busy     = (r_state != ST_IDLE);
        hsync    = 1'b1;
        vsync    = 1'b1;
        video_on = 1'b0;
        if (busy) begin
            hsync    = !((w_h_count >= HS_BEGIN) && (w_h_count < HS_END));
            vsync    = !((w_v_count >= VS_BEGIN) && (w_v_count < VS_END));
            video_on = (w_h_count < H_VIS) && (w_v_count < V_VIS);
        end
    end

    assign hCount      = w_h_count;
    assign vCount      = w_v_count;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Testbench for vga_timing_ctrl.
// DUT A uses the 640x480 defaults (start-up, line timing, freeze, mid-line reset).
// DUT B uses a miniature 16x8 timing so full frames and stop/restart fit in a short run:
//   H: 8 active, 2 fp, 3 sync, 3 bp -> hsync low at h 10..12
//   V: 4 active, 1 fp, 2 sync, 1 bp -> vsync low on lines 5..6, 128 ticks per frame
module tb_vga_timing_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en_a, tick_a, en_b, tick_b;

    logic [9:0] a_h, a_v, b_h, b_v;
    logic       a_hs, a_vs, a_vo, a_ls, a_fs, a_busy;
    logic       b_hs, b_vs, b_vo, b_ls, b_fs, b_busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    vga_timing_ctrl u_dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .pix_tick    (tick_a),
        .en          (en_a),
        .hCount      (a_h),
        .vCount      (a_v),
        .hsync       (a_hs),
        .vsync       (a_vs),
        .video_on    (a_vo),
        .line_start  (a_ls),
        .frame_start (a_fs),
        .busy        (a_busy)
    );

    vga_timing_ctrl #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
        .V_ACTIVE (4), .V_FP (1), .V_SYNC (2), .V_BP (1)
    ) u_dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .pix_tick    (tick_b),
        .en          (en_b),
        .hCount      (b_h),
        .vCount      (b_v),
        .hsync       (b_hs),
        .vsync       (b_vs),
        .video_on    (b_vo),
        .line_start  (b_ls),
        .frame_start (b_fs),
        .busy        (b_busy)
    );

    typedef struct {
        logic en;
        logic tick;
        int   h, v, hs, vs, vo, ls, fs, busy;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input int eh, ev, ehs, evs, evo, els, efs, ebusy);
        check({tag, " hCount"},      int'(a_h),    eh);
        check({tag, " vCount"},      int'(a_v),    ev);
        check({tag, " hsync"},       int'(a_hs),   ehs);
        check({tag, " vsync"},       int'(a_vs),   evs);
        check({tag, " video_on"},    int'(a_vo),   evo);
        check({tag, " line_start"},  int'(a_ls),   els);
        check({tag, " frame_start"}, int'(a_fs),   efs);
        check({tag, " busy"},        int'(a_busy), ebusy);
    endtask

    task automatic chk_b(input string tag, input int eh, ev, ehs, evs, evo, els, efs, ebusy);
        check({tag, " hCount"},      int'(b_h),    eh);
        check({tag, " vCount"},      int'(b_v),    ev);
        check({tag, " hsync"},       int'(b_hs),   ehs);
        check({tag, " vsync"},       int'(b_vs),   evs);
        check({tag, " video_on"},    int'(b_vo),   evo);
        check({tag, " line_start"},  int'(b_ls),   els);
        check({tag, " frame_start"}, int'(b_fs),   efs);
        check({tag, " busy"},        int'(b_busy), ebusy);
    endtask

    initial begin
        int exp_h, exp_v, lows, first_low, ls_cnt, fs_cnt, bad;
        int p, eh, ev, pbad, hbad, vbad, obad, lbad, vs_low, busy_bad;

        //            en    tick  h  v  hs vs vo ls fs busy
        tbl[0] = '{1'b0, 1'b1, 0, 0, 1, 1, 0, 0, 0, 0}; // tick ignored in IDLE
        tbl[1] = '{1'b1, 1'b1, 0, 0, 1, 1, 1, 1, 1, 1}; // enter RUN, tick dropped
        tbl[2] = '{1'b1, 1'b0, 0, 0, 1, 1, 1, 0, 0, 1};
        tbl[3] = '{1'b1, 1'b0, 0, 0, 1, 1, 1, 0, 0, 1};
        tbl[4] = '{1'b1, 1'b0, 0, 0, 1, 1, 1, 0, 0, 1};
        tbl[5] = '{1'b1, 1'b1, 1, 0, 1, 1, 1, 0, 0, 1};
        tbl[6] = '{1'b1, 1'b0, 1, 0, 1, 1, 1, 0, 0, 1};
        tbl[7] = '{1'b1, 1'b0, 1, 0, 1, 1, 1, 0, 0, 1};
        tbl[8] = '{1'b1, 1'b0, 1, 0, 1, 1, 1, 0, 0, 1};
        tbl[9] = '{1'b1, 1'b1, 2, 0, 1, 1, 1, 0, 0, 1};

        rst_n = 1'b0; en_a = 1'b0; tick_a = 1'b0; en_b = 1'b0; tick_b = 1'b0;
        cyc();
        cyc();
        chk_a("rstA", 0, 0, 1, 1, 0, 0, 0, 0);
        chk_b("rstB", 0, 0, 1, 1, 0, 0, 0, 0);
        rst_n = 1'b1;

        // ---- DUT A: start-up with a tick every 4th clk ----
        for (int i = 0; i < 10; i++) begin
            en_a   = tbl[i].en;
            tick_a = tbl[i].tick;
            cyc();
            chk_a($sformatf("vec%0d", i), tbl[i].h, tbl[i].v, tbl[i].hs, tbl[i].vs,
                  tbl[i].vo, tbl[i].ls, tbl[i].fs, tbl[i].busy);
        end

        // ---- DUT A: rest of line 0, one tick per clk ----
        tick_a = 1'b1;
        exp_h = 2; lows = 0; first_low = -1; ls_cnt = 0;
        for (int k = 0; k < 797; k++) begin
            cyc();
            exp_h++;
            if (a_hs == 1'b0) begin
                lows++;
                if (first_low < 0) first_low = int'(a_h);
            end
            ls_cnt += int'(a_ls);
            if (exp_h == 639) check("vo@639", int'(a_vo), 1);
            if (exp_h == 640) check("vo@640", int'(a_vo), 0);
            if (exp_h == 655) check("hs@655", int'(a_hs), 1);
            if (exp_h == 751) check("hs@751", int'(a_hs), 0);
            if (exp_h == 752) check("hs@752", int'(a_hs), 1);
        end
        check("h@end", int'(a_h), 799);
        check("v@end", int'(a_v), 0);
        check("hsync low ticks", lows, 96);
        check("hsync first low", first_low, 656);
        check("line_start in line", ls_cnt, 0);
        cyc();
        chk_a("wrapA", 0, 1, 1, 1, 1, 1, 0, 1);
        cyc();
        chk_a("wrapA+1", 1, 1, 1, 1, 1, 0, 0, 1);

        // ---- DUT A: pix_tick held low for 50 clk ----
        tick_a = 1'b0;
        bad = 0;
        for (int k = 0; k < 50; k++) begin
            cyc();
            if (a_h != 10'd1 || a_v != 10'd1 || !a_hs || !a_vs || !a_vo ||
                a_ls || a_fs || !a_busy) bad++;
        end
        check("freeze", bad, 0);

        // ---- DUT A: reset mid-line inside hsync ----
        tick_a = 1'b1;
        for (int k = 0; k < 699; k++) cyc();
        chk_a("at700", 700, 1, 0, 1, 0, 0, 0, 1);
        rst_n = 1'b0;
        cyc();
        chk_a("midrst", 0, 0, 1, 1, 0, 0, 0, 0);
        rst_n = 1'b1; tick_a = 1'b0;
        cyc();
        chk_a("rerun", 0, 0, 1, 1, 1, 1, 1, 1);
        en_a = 1'b0;

        // ---- DUT B: full frame ----
        en_b = 1'b1; tick_b = 1'b0;
        cyc();
        chk_b("startB", 0, 0, 1, 1, 1, 1, 1, 1);
        tick_b = 1'b1;
        p = 0; pbad = 0; hbad = 0; vbad = 0; obad = 0; lbad = 0; vs_low = 0; fs_cnt = 0;
        for (int k = 1; k <= 128; k++) begin
            cyc();
            p = (p + 1) % 128;
            eh = p % 16;
            ev = p / 16;
            if (int'(b_h) != eh || int'(b_v) != ev) pbad++;
            if (b_hs != !(eh >= 10 && eh <= 12)) hbad++;
            if (b_vs != !(ev == 5 || ev == 6)) vbad++;
            if (b_vo != (eh < 8 && ev < 4)) obad++;
            if (b_ls != (eh == 0)) lbad++;
            if (b_vs == 1'b0) vs_low++;
            if (k < 128) fs_cnt += int'(b_fs);
        end
        check("B position", pbad, 0);
        check("B hsync", hbad, 0);
        check("B vsync", vbad, 0);
        check("B video_on", obad, 0);
        check("B line_start", lbad, 0);
        check("B vsync low ticks", vs_low, 32);
        check("B frame_start in frame", fs_cnt, 0);
        chk_b("B frame wrap", 0, 0, 1, 1, 1, 1, 1, 1);

        // ---- DUT B: drop en at (3,2), last frame completes then IDLE ----
        for (int k = 0; k < 35; k++) cyc();
        check("B h@35", int'(b_h), 3);
        check("B v@35", int'(b_v), 2);
        en_b = 1'b0; tick_b = 1'b0;
        cyc();
        chk_b("B stop", 3, 2, 1, 1, 1, 0, 0, 1);
        tick_b = 1'b1;
        busy_bad = 0; fs_cnt = 0;
        for (int k = 1; k <= 93; k++) begin
            cyc();
            if (k == 50) chk_b("B stop mid", 5, 5, 1, 0, 0, 0, 0, 1);
            if (k < 93) begin
                if (!b_busy) busy_bad++;
                fs_cnt += int'(b_fs);
            end
        end
        check("B busy during stop", busy_bad, 0);
        check("B frame_start during stop", fs_cnt, 0);
        chk_b("B idle", 0, 0, 1, 1, 0, 0, 0, 0);
        for (int k = 0; k < 20; k++) cyc();
        chk_b("B idle hold", 0, 0, 1, 1, 0, 0, 0, 0);

        // ---- DUT B: stop then re-raise en mid-frame ----
        en_b = 1'b1; tick_b = 1'b0;
        cyc();
        chk_b("B restart", 0, 0, 1, 1, 1, 1, 1, 1);
        tick_b = 1'b1;
        for (int k = 0; k < 40; k++) cyc();
        en_b = 1'b0;
        for (int k = 0; k < 10; k++) cyc();
        chk_b("B stopped", 2, 3, 1, 1, 1, 0, 0, 1);
        en_b = 1'b1;
        cyc();
        chk_b("B resumed", 3, 3, 1, 1, 1, 0, 0, 1);
        fs_cnt = 0; busy_bad = 0;
        for (int k = 1; k <= 77; k++) begin
            cyc();
            if (k < 77) begin
                fs_cnt += int'(b_fs);
                if (!b_busy) busy_bad++;
            end
        end
        check("B resume frame_start", fs_cnt, 0);
        check("B resume busy", busy_bad, 0);
        chk_b("B next frame", 0, 0, 1, 1, 1, 1, 1, 1);
        en_b = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
